button_press_bank: RTL and testbench

//  Parametrised bank of NUM_BUTTONS debounced push-button press detectors for front-panel and board inputs.

---
 rtl/button_press_bank_pkg.sv | 18 +
 rtl/button_channel.sv | 100 ++++++++++
 rtl/button_press_bank.sv | 49 ++++
 tb/tb_button_press_bank.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_press_bank_pkg.sv
// Shared state encodings and helpers for the debounced push-button bank.
package button_press_bank_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        BTN_UP      = 3'b000,
        DEBOUNCE_DN = 3'b001,
        BTN_PRESSED = 3'b010,
        WAIT_UP     = 3'b011,
        DEBOUNCE_UP = 3'b100
    } btn_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, press/release debounce FSM,
// latched press event and optional auto-repeat while held.
module button_channel
    import button_press_bank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 8
) (
    input  logic clock,
    input  logic resetN,
    input  logic buttonDown,
    input  logic ackPress,
    output logic wasPressed
);

    localparam int CNT_MAX = max_int(DEBOUNCE_CYCLES, REPEAT_DELAY);
    localparam int CNT_W   = max_int($clog2(CNT_MAX), 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam bit REPEAT_ON = (REPEAT_EN != 0);

    logic [1:0]       r_sync;
    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_s;

    assign w_s = r_sync[1];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_sync  <= '0;
            r_state <= BTN_UP;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], buttonDown};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            BTN_UP: begin
                w_cnt_nxt = '0;
                if (w_s) w_state_nxt = DEBOUNCE_DN;
            end
            DEBOUNCE_DN: begin
                if (!w_s) begin
                    w_state_nxt = BTN_UP;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = BTN_PRESSED;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            // Event stays latched until acked, even if released.
            BTN_PRESSED: begin
                if (ackPress) begin
                    w_state_nxt = WAIT_UP;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_UP: begin
                if (!w_s) begin
                    w_state_nxt = DEBOUNCE_UP;
                    w_cnt_nxt   = '0;
                end else if (REPEAT_ON && r_cnt == RPT_LAST) begin
                    w_state_nxt = BTN_PRESSED;
                end else if (r_cnt != CNT_SAT) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DEBOUNCE_UP: begin
                if (w_s) begin
                    w_state_nxt = WAIT_UP;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = BTN_UP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = BTN_UP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign wasPressed = (r_state == BTN_PRESSED);

endmodule

// File: rtl/button_press_bank.sv
// Bank of debounced button channels with a lowest-index-wins
// priority encoder over the pending press flags.
module button_press_bank
    import button_press_bank_pkg::*;
#(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 8,
    localparam int IDX_W          = max_int($clog2(NUM_BUTTONS), 1)
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic [NUM_BUTTONS-1:0] buttonDown,
    input  logic [NUM_BUTTONS-1:0] ackPress,
    output logic [NUM_BUTTONS-1:0] wasPressed,
    output logic                   anyPressed,
    output logic [IDX_W-1:0]       pressedIndex
);

    logic [IDX_W-1:0] w_idx;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (REPEAT_EN),
            .REPEAT_DELAY   (REPEAT_DELAY)
        ) u_ch (
            .clock     (clock),
            .resetN    (resetN),
            .buttonDown(buttonDown[g]),
            .ackPress  (ackPress[g]),
            .wasPressed(wasPressed[g])
        );
    end

    assign anyPressed = |wasPressed;

    // Scan high to low so the lowest pending index is written last.
    always_comb begin
        w_idx = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (wasPressed[i]) w_idx = IDX_W'(i);
        end
    end

    assign pressedIndex = w_idx;

endmodule

// File: tb/tb_button_press_bank.sv
// Directed bench for button_press_bank: one instance without
// auto-repeat and one with it, sharing the same stimulus.
module tb_button_press_bank;

    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic [3:0] buttonDown = '0;
    logic [3:0] ackPress = '0;
    logic [3:0] wp;
    logic       any;
    logic [1:0] idx;
    logic [3:0] wp_r;
    logic       any_r;
    logic [1:0] idx_r;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    button_press_bank #(
        .NUM_BUTTONS(4), .DEBOUNCE_CYCLES(4),
        .REPEAT_EN(0), .REPEAT_DELAY(8)
    ) dut (
        .clock(clock), .resetN(resetN),
        .buttonDown(buttonDown), .ackPress(ackPress),
        .wasPressed(wp), .anyPressed(any), .pressedIndex(idx)
    );

    button_press_bank #(
        .NUM_BUTTONS(4), .DEBOUNCE_CYCLES(4),
        .REPEAT_EN(1), .REPEAT_DELAY(8)
    ) dut_rep (
        .clock(clock), .resetN(resetN),
        .buttonDown(buttonDown), .ackPress(ackPress),
        .wasPressed(wp_r), .anyPressed(any_r), .pressedIndex(idx_r)
    );

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        buttonDown = '0;
        ackPress   = '0;
        resetN     = 1'b0;
        tick(2);
        resetN = 1'b1;
    endtask

    task automatic ack(input logic [3:0] a);
        ackPress = a;
        tick(1);
        ackPress = '0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        #3;
        checks++;
        if ({wp, any, idx} !== 7'b0 || {wp_r, any_r, idx_r} !== 7'b0) begin
            errors++;
            $display("FAIL reset: got %b/%b/%0d want 0/0/0", wp, any, idx);
        end
        do_reset();
    endtask

    task automatic test_press();
        do_reset();
        buttonDown = 4'b0100;
        tick(6);
        checks++;
        if (wp !== 4'b0000) begin
            errors++;
            $display("FAIL press_edge6: got %b want 0000", wp);
        end
        tick(1);
        checks++;
        if (wp !== 4'b0100 || any !== 1'b1 || idx !== 2'd2) begin
            errors++;
            $display("FAIL press_edge7: got %b/%b/%0d want 0100/1/2",
                     wp, any, idx);
        end
        buttonDown = '0;
        tick(3);
        checks++;
        if (wp !== 4'b0100) begin
            errors++;
            $display("FAIL press_latched: got %b want 0100", wp);
        end
        ack(4'b0100);
        checks++;
        if (wp !== 4'b0000 || any !== 1'b0) begin
            errors++;
            $display("FAIL press_ack: got %b/%b want 0000/0", wp, any);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        buttonDown = 4'b0001;
        tick(3);
        buttonDown = 4'b0000;
        tick(1);
        buttonDown = 4'b0001;
        tick(2);
        checks++;
        if (wp !== 4'b0000) begin
            errors++;
            $display("FAIL bounce_first: got %b want 0000", wp);
        end
        tick(4);
        checks++;
        if (wp !== 4'b0000) begin
            errors++;
            $display("FAIL bounce_rise6: got %b want 0000", wp);
        end
        tick(1);
        checks++;
        if (wp !== 4'b0001 || idx !== 2'd0 || any !== 1'b1) begin
            errors++;
            $display("FAIL bounce_rise7: got %b/%b/%0d want 0001/1/0",
                     wp, any, idx);
        end
    endtask

    task automatic test_repeat();
        do_reset();
        buttonDown = 4'b0100;
        tick(9);
        ack(4'b0100);
        checks++;
        if (wp[2] !== 1'b0 || wp_r[2] !== 1'b0) begin
            errors++;
            $display("FAIL repeat_ack: got %b/%b want 0/0", wp[2], wp_r[2]);
        end
        tick(7);
        checks++;
        if (wp_r[2] !== 1'b0) begin
            errors++;
            $display("FAIL repeat_edge17: got %b want 0", wp_r[2]);
        end
        tick(1);
        checks++;
        if (wp_r[2] !== 1'b1 || idx_r !== 2'd2) begin
            errors++;
            $display("FAIL repeat_edge18: got %b/%0d want 1/2",
                     wp_r[2], idx_r);
        end
        checks++;
        if (wp[2] !== 1'b0) begin
            errors++;
            $display("FAIL norepeat_edge18: got %b want 0", wp[2]);
        end
        tick(20);
        checks++;
        if (wp !== 4'b0000) begin
            errors++;
            $display("FAIL norepeat_held: got %b want 0000", wp);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        buttonDown = 4'b1010;
        tick(7);
        checks++;
        if (wp !== 4'b1010 || idx !== 2'd1 || any !== 1'b1) begin
            errors++;
            $display("FAIL simul_both: got %b/%b/%0d want 1010/1/1",
                     wp, any, idx);
        end
        ack(4'b0010);
        checks++;
        if (wp !== 4'b1000 || idx !== 2'd3) begin
            errors++;
            $display("FAIL simul_ack1: got %b/%0d want 1000/3", wp, idx);
        end
        ack(4'b1000);
        checks++;
        if (any !== 1'b0 || idx !== 2'd0 || wp !== 4'b0000) begin
            errors++;
            $display("FAIL simul_ack3: got %b/%b/%0d want 0000/0/0",
                     wp, any, idx);
        end
        do_reset();
        buttonDown = 4'b0110;
        tick(7);
        ack(4'b0110);
        checks++;
        if (wp !== 4'b0000) begin
            errors++;
            $display("FAIL simul_dual_ack: got %b want 0000", wp);
        end
    endtask

    task automatic test_repress();
        do_reset();
        buttonDown = 4'b0010;
        tick(7);
        ack(4'b0010);
        buttonDown = 4'b0000;
        tick(2);
        buttonDown = 4'b0010;
        tick(15);
        checks++;
        if (wp !== 4'b0000) begin
            errors++;
            $display("FAIL repress_short: got %b want 0000", wp);
        end
        buttonDown = 4'b0000;
        tick(10);
        buttonDown = 4'b0010;
        tick(6);
        checks++;
        if (wp !== 4'b0000) begin
            errors++;
            $display("FAIL repress_edge6: got %b want 0000", wp);
        end
        tick(1);
        checks++;
        if (wp !== 4'b0010 || idx !== 2'd1) begin
            errors++;
            $display("FAIL repress_new: got %b/%0d want 0010/1", wp, idx);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        buttonDown = 4'b1000;
        tick(3);
        buttonDown = 4'b1001;
        tick(4);
        checks++;
        if (wp !== 4'b1000 || idx !== 2'd3) begin
            errors++;
            $display("FAIL midrst_pre: got %b/%0d want 1000/3", wp, idx);
        end
        #2;
        resetN = 1'b0;
        #1;
        checks++;
        if (wp !== 4'b0000 || any !== 1'b0 || idx !== 2'd0) begin
            errors++;
            $display("FAIL midrst_async: got %b/%b/%0d want 0000/0/0",
                     wp, any, idx);
        end
        tick(2);
        resetN = 1'b1;
        tick(6);
        checks++;
        if (wp !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_edge6: got %b want 0000", wp);
        end
        tick(1);
        checks++;
        if (wp !== 4'b1001 || idx !== 2'd0 || any !== 1'b1) begin
            errors++;
            $display("FAIL midrst_edge7: got %b/%b/%0d want 1001/1/0",
                     wp, any, idx);
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_repeat();
        test_simultaneous();
        test_repress();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
